// File: rtl/bus_defs.sv
// Shared bus definitions.
// Holds the arbiter state encoding and the shared data/address width so that
// every block attached to the shared bus (arbiter, address decoders) agrees on them.
package bus_defs;

    // Width of the shared address and data buses.
    localparam int BUS_W = 16;

    // Arbiter states: IDLE waits for a request, BUSY owns the shared bus.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector (purely combinational).
// Ports:
//   req   [1:0]  request vector, bit i set when master i is requesting
//   last         index of the master granted most recently
//   grant        index of the selected master (meaningful only when req != 0)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            // Contention: the master that did not win last time goes first.
            grant = ~last;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter with timeout.
// A request is latched in IDLE, driven onto the shared bus for every BUSY
// cycle, and completed either by s_ready (normal) or by the wait counter
// reaching TIMEOUT-1 (abort: ready + error, rdata = ERR_DATA).
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   mN_read/write/address/wdata  master N request (held until mN_ready)
//   mN_rdata/ready/error       master N response (one-cycle pulse)
//   s_read/write/address/wdata shared-bus request
//   s_rdata/s_ready            shared-bus response
module bus_arbiter
    import bus_defs::*;
#(
    parameter int              TIMEOUT  = 16,
    parameter logic [BUS_W-1:0] ERR_DATA = 16'hffff
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_read,
    input  logic             m0_write,
    input  logic [BUS_W-1:0] m0_address,
    input  logic [BUS_W-1:0] m0_wdata,
    output logic [BUS_W-1:0] m0_rdata,
    output logic             m0_ready,
    output logic             m0_error,
    input  logic             m1_read,
    input  logic             m1_write,
    input  logic [BUS_W-1:0] m1_address,
    input  logic [BUS_W-1:0] m1_wdata,
    output logic [BUS_W-1:0] m1_rdata,
    output logic             m1_ready,
    output logic             m1_error,
    output logic             s_read,
    output logic             s_write,
    output logic [BUS_W-1:0] s_address,
    output logic [BUS_W-1:0] s_wdata,
    input  logic [BUS_W-1:0] s_rdata,
    input  logic             s_ready
);

    localparam int               CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             owner_reg, owner_next;
    logic             last_reg, last_next;
    logic             lat_read_reg, lat_read_next;
    logic             lat_write_reg, lat_write_next;
    logic [BUS_W-1:0] lat_addr_reg, lat_addr_next;
    logic [BUS_W-1:0] lat_wdata_reg, lat_wdata_next;

    logic [1:0]       req;
    logic             grant;
    logic             done;
    logic             abort;
    logic             bus_on;
    logic [BUS_W-1:0] resp_data;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (last_reg),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            owner_reg     <= 1'b0;
            last_reg      <= 1'b1;
            lat_read_reg  <= 1'b0;
            lat_write_reg <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            lat_read_reg  <= lat_read_next;
            lat_write_reg <= lat_write_next;
            lat_addr_reg  <= lat_addr_next;
            lat_wdata_reg <= lat_wdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        owner_next     = owner_reg;
        last_next      = last_reg;
        lat_read_next  = lat_read_reg;
        lat_write_next = lat_write_reg;
        lat_addr_next  = lat_addr_reg;
        lat_wdata_next = lat_wdata_reg;
        done           = 1'b0;
        abort          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    state_next     = BUSY;
                    owner_next     = grant;
                    cnt_next       = '0;
                    lat_write_next = grant ? m1_write : m0_write;
                    // Write wins when both strobes are raised together.
                    lat_read_next  = grant ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
                    lat_addr_next  = grant ? m1_address : m0_address;
                    lat_wdata_next = grant ? m1_wdata : m0_wdata;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    // s_ready takes priority, even on the final timeout cycle.
                    done       = 1'b1;
                    state_next = IDLE;
                    last_next  = owner_reg;
                end else if (cnt_reg == CNT_LAST) begin
                    done       = 1'b1;
                    abort      = 1'b1;
                    state_next = IDLE;
                    last_next  = owner_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Every output is forced low while reset is asserted, so a reset that
    // lands in BUSY never leaks a completion pulse.
    assign bus_on    = (state_reg == BUSY) && !reset;
    assign s_read    = bus_on & lat_read_reg;
    assign s_write   = bus_on & lat_write_reg;
    assign s_address = bus_on ? lat_addr_reg : '0;
    assign s_wdata   = bus_on ? lat_wdata_reg : '0;
    assign resp_data = abort ? ERR_DATA : s_rdata;

    logic [1:0]       rdy_vec;
    logic [1:0]       err_vec;
    logic [BUS_W-1:0] rdata_vec [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic hit;
            assign hit           = done && !reset && (owner_reg == gi[0]);
            assign rdy_vec[gi]   = hit;
            assign err_vec[gi]   = hit & abort;
            assign rdata_vec[gi] = hit ? resp_data : '0;
        end
    endgenerate

    assign m0_ready = rdy_vec[0];
    assign m0_error = err_vec[0];
    assign m0_rdata = rdata_vec[0];
    assign m1_ready = rdy_vec[1];
    assign m1_error = err_vec[1];
    assign m1_rdata = rdata_vec[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes the expected completion of
// each access; a monitor pops and compares whenever a master sees ready.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
    logic [15:0] m0_address = 0, m0_wdata = 0, m1_address = 0, m1_wdata = 0;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_ready, m0_error, m1_ready, m1_error;
    logic        s_read, s_write;
    logic [15:0] s_address, s_wdata;
    logic [15:0] s_rdata = 0;
    logic        s_ready = 0;

    int checks = 0;
    int failures = 0;

    // Slave behaviour: ready on the ready_at-th BUSY cycle (0 = never).
    int          ready_at = 1;
    logic [15:0] slave_rdata = 16'h0;

    typedef struct {
        int          m;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];

    bus_arbiter #(.TIMEOUT(16), .ERR_DATA(16'hffff)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_error(m0_error),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_error(m1_error),
        .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(int m, logic rd, logic wr, logic [15:0] a, logic [15:0] wd,
                                logic [15:0] rdv, logic err, int cyc);
        exp_t e;
        e.m = m; e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd;
        e.rdata = rdv; e.err = err; e.cycles = cyc;
        return e;
    endfunction

    // Slave model, updated just after each rising edge.
    initial begin
        int busy_s;
        busy_s = 0;
        forever begin
            @(posedge clk);
            #1;
            if (s_read || s_write) busy_s++;
            else busy_s = 0;
            s_ready = (ready_at != 0) && (busy_s == ready_at);
            s_rdata = s_ready ? slave_rdata : 16'h0;
        end
    end

    // Monitor: compares each completion with the head of the scoreboard.
    initial begin
        int   mon_busy;
        exp_t e;
        mon_busy = 0;
        forever begin
            @(negedge clk);
            if (s_read || s_write) mon_busy++;
            if (m0_ready || m1_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready m0_ready=%0b m1_ready=%0b expected=none t=%0t",
                             m0_ready, m1_ready, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("both_ready", {31'b0, m0_ready & m1_ready}, 32'd0);
                    chk("owner", {31'b0, m1_ready}, e.m);
                    if (e.m == 0) begin
                        chk("m0_rdata", m0_rdata, e.rdata);
                        chk("m0_error", m0_error, e.err);
                        chk("m1_idle_out", {m1_ready, m1_error, m1_rdata}, 32'd0);
                    end else begin
                        chk("m1_rdata", m1_rdata, e.rdata);
                        chk("m1_error", m1_error, e.err);
                        chk("m0_idle_out", {m0_ready, m0_error, m0_rdata}, 32'd0);
                    end
                    chk("s_read", s_read, e.rd);
                    chk("s_write", s_write, e.wr);
                    chk("s_address", s_address, e.addr);
                    chk("s_wdata", s_wdata, e.wdata);
                    chk("busy_cycles", mon_busy, e.cycles);
                    $display("txn m%0d rd=%0b wr=%0b addr=%04h rdata=%04h err=%0b cycles=%0d",
                             e.m, s_read, s_write, s_address,
                             (e.m == 0) ? m0_rdata : m1_rdata,
                             (e.m == 0) ? m0_error : m1_error, mon_busy);
                end
            end
            if (!(s_read || s_write)) mon_busy = 0;
        end
    end

    // Issue one request from master m and hold it until that master's ready.
    task automatic master_req(input int m, input logic rd, input logic wr,
                              input logic [15:0] a, input logic [15:0] wd);
        bool_t_dummy: begin end
        @(posedge clk);
        #1;
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_wdata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_wdata = wd;
        end
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                seen = (m == 0) ? m0_ready : m1_ready;
            end
            if (!seen) begin
                checks++;
                failures++;
                $display("FAIL ready_wait master=%0d actual=no_ready expected=ready", m);
            end
        end
        @(posedge clk);
        #1;
        if (m == 0) begin
            m0_read = 0; m0_write = 0;
        end else begin
            m1_read = 0; m1_write = 0;
        end
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {m0_ready, m0_error, m1_ready, m1_error, s_read, s_write, 26'b0}, 32'd0);
        chk({name, "_data"}, {m0_rdata, m1_rdata}, 32'd0);
        chk({name, "_bus"}, {s_address, s_wdata}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check_all_zero("idle_outputs");

        // 1: m0 read, ready on 3rd BUSY cycle.
        ready_at = 3; slave_rdata = 16'h1234;
        exp_q.push_back(mk(0, 1, 0, 16'h0010, 16'h0000, 16'h1234, 0, 3));
        master_req(0, 1, 0, 16'h0010, 16'h0000);

        // 2: simultaneous requests after reset alternate m0, m1, m0, m1.
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        ready_at = 1; slave_rdata = 16'h5a5a;
        exp_q.push_back(mk(0, 1, 0, 16'h0100, 16'h0000, 16'h5a5a, 0, 1));
        exp_q.push_back(mk(1, 1, 0, 16'h0200, 16'h0000, 16'h5a5a, 0, 1));
        fork
            master_req(0, 1, 0, 16'h0100, 16'h0000);
            master_req(1, 1, 0, 16'h0200, 16'h0000);
        join
        exp_q.push_back(mk(0, 1, 0, 16'h0300, 16'h0000, 16'h5a5a, 0, 1));
        exp_q.push_back(mk(1, 1, 0, 16'h0400, 16'h0000, 16'h5a5a, 0, 1));
        fork
            master_req(0, 1, 0, 16'h0300, 16'h0000);
            master_req(1, 1, 0, 16'h0400, 16'h0000);
        join

        // 3: m1 write to 0xffff while m0 also requests; last was m1's turn? No:
        // last-granted is m1 after step 2, so m0 would win; serve one m0 first.
        ready_at = 2; slave_rdata = 16'h0bcd;
        exp_q.push_back(mk(0, 1, 0, 16'h0500, 16'h0000, 16'h0bcd, 0, 2));
        master_req(0, 1, 0, 16'h0500, 16'h0000);
        exp_q.push_back(mk(1, 0, 1, 16'hffff, 16'h00aa, 16'h0bcd, 0, 2));
        exp_q.push_back(mk(0, 1, 0, 16'h0600, 16'h0000, 16'h0bcd, 0, 2));
        fork
            master_req(1, 0, 1, 16'hffff, 16'h00aa);
            master_req(0, 1, 0, 16'h0600, 16'h0000);
        join

        // 4: timeout after 16 BUSY cycles.
        ready_at = 0; slave_rdata = 16'h0000;
        exp_q.push_back(mk(0, 1, 0, 16'h0700, 16'h0000, 16'hffff, 1, 16));
        master_req(0, 1, 0, 16'h0700, 16'h0000);
        @(negedge clk);
        check_all_zero("post_timeout_idle");

        // 5: reset in the 2nd BUSY cycle; last-granted returns to m1.
        @(posedge clk);
        #1 m0_read = 1; m0_address = 16'h0800;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1;
        #1 check_all_zero("in_reset_busy");
        @(posedge clk);
        #1 reset = 0; m0_read = 0;
        @(negedge clk);
        check_all_zero("after_reset_busy");
        ready_at = 1; slave_rdata = 16'h4321;
        exp_q.push_back(mk(0, 1, 0, 16'h0900, 16'h0000, 16'h4321, 0, 1));
        exp_q.push_back(mk(1, 1, 0, 16'h0a00, 16'h0000, 16'h4321, 0, 1));
        fork
            master_req(0, 1, 0, 16'h0900, 16'h0000);
            master_req(1, 1, 0, 16'h0a00, 16'h0000);
        join

        // 6: read and write together -> write.
        ready_at = 1; slave_rdata = 16'h0042;
        exp_q.push_back(mk(0, 0, 1, 16'h8000, 16'h1111, 16'h0042, 0, 1));
        master_req(0, 1, 1, 16'h8000, 16'h1111);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of BUSY cycles spent waiting for s_ready before the access is aborted.
REQ-002 The block SHALL have parameter ERR_DATA, default 16'hffff, meaning the read data returned on an aborted access.
REQ-003 The block SHALL have the following ports, one per line.
- clk  input  1  single clock; all logic is on the rising edge.
- reset  input  1  synchronous reset, active-high.
- m0_read, m0_write  input  1 each  master 0 request strobes, held until m0_ready.
- m0_address  input  16  master 0 address.
- m0_wdata  input  16  master 0 write data.
- m0_rdata  output  16  master 0 read data.
- m0_ready  output  1  master 0 completion pulse.
- m0_error  output  1  master 0 timeout flag.
- m1_*  same set as m0_*  master 1.
- s_read, s_write  output  1 each  shared-bus strobes.
- s_address  output  16  shared-bus address.
- s_wdata  output  16  shared-bus write data.
- s_rdata  input  16  shared-bus read data.
- s_ready  input  1  shared-bus completion.

Function
REQ-004 The block SHALL implement states IDLE and BUSY.
REQ-005 In IDLE, s_read, s_write, s_address and s_wdata SHALL be 0.
REQ-006 In IDLE, a master is requesting when its read or write strobe is 1.
REQ-007 At the clock edge in IDLE where at least one master is requesting, the block SHALL perform the following actions:
- grant one master;
- latch that master's address, wdata and strobes;
- enter BUSY;
- clear the wait counter.
REQ-008 Arbitration SHALL be two-way round-robin:
- a sole requester wins;
- when both masters request, the master not granted last wins;
- after reset, last-granted is m1, so m0 wins first.
REQ-009 The latched request SHALL drive the s_* outputs for every BUSY cycle.
- Latency: request sampled at edge N; s_read or s_write is asserted from cycle N+1.
REQ-010 When a master asserts read and write together, the write SHALL be performed; s_read SHALL be 0.
REQ-011 In BUSY with s_ready=1, the block SHALL complete the access as follows:
- the owner's mN_ready SHALL be 1 for that cycle;
- the owner's mN_rdata SHALL equal s_rdata for that cycle;
- mN_error SHALL be 0;
- the next state SHALL be IDLE;
- last-granted SHALL be updated to the owner.
REQ-012 In BUSY with s_ready=0, the wait counter SHALL increment by 1 per cycle. Its width is clog2(TIMEOUT)+1, and it never wraps.
REQ-013 When the counter equals TIMEOUT-1 and s_ready=0, the block SHALL abort the access as follows:
- the owner's mN_ready and mN_error SHALL both be 1 for that cycle;
- mN_rdata SHALL equal ERR_DATA;
- the next state SHALL be IDLE;
- last-granted SHALL be updated.
REQ-014 When s_ready=1 arrives in the cycle the counter hits TIMEOUT-1, the access SHALL be treated as a normal completion, with no error.
REQ-015 The non-owner master SHALL see ready=0, error=0 and rdata=0 throughout.
- A request from the non-owner during BUSY is stalled, not dropped; it is arbitrated in the next IDLE.
REQ-016 Masters SHALL deassert their strobes in the cycle after mN_ready.
- The mandatory IDLE cycle between accesses guarantees that stale strobes are never re-granted.
REQ-017 Back-to-back throughput SHALL be at most one access per (BUSY cycles + 1).

Reset
REQ-018 When reset=1 at a clock edge, the block SHALL return to the following state:
- state IDLE;
- last-granted m1;
- counter 0;
- latched request cleared.
REQ-019 While in reset, all outputs SHALL be 0: m0_ready, m0_error, m0_rdata, m1_ready, m1_error, m1_rdata, s_read, s_write, s_address, s_wdata.
REQ-020 Reset during BUSY SHALL abandon the access without any ready or error pulse.

Structure
REQ-021 The state encoding (IDLE=0, BUSY=1) and the bus width constant (16) SHALL live in the shared header bus_defs.
- The computer-level decoders include the same header.
REQ-022 Round-robin selection SHALL be a sub-module, rr_arb2, with the following behaviour:
- inputs: req[1:0] and last;
- output: grant index;
- combinational only.

Verification
REQ-023 The bench SHALL cover the following directed scenarios.
- m0 reads 0x0010; s_ready on the 3rd BUSY cycle with s_rdata 0x1234. Required: s_read=1 and s_address=0x0010 for 3 cycles, m0_ready pulse with m0_rdata=0x1234, m0_error=0.
- m0 and m1 request together after reset. Required: m0 is served, then m1. When both request again, m1 is not preferred: m0 is served (round-robin alternation).
- m1 writes address 0xffff with data 0x00aa while m0 also requests. Required: s_write=1 and s_wdata=0x00aa; m0 is held (m0_ready=0) until m1 completes.
- TIMEOUT=16; m0 reads and s_ready stays 0. Required: after 16 BUSY cycles, m0_ready=m0_error=1 and m0_rdata=0xffff; then IDLE.
- reset=1 in the 2nd BUSY cycle. Required: next cycle all outputs are 0, no ready pulse; the next request goes to m0.
- m0 asserts read and write together with address 0x8000. Required: s_write=1 and s_read=0.
